pipeline_hazard_ctrl: RTL and testbench

//   Sequencer for the 5-stage MIPS pipeline. Sits beside the IF/ID, ID/EX and EX/MEM

---
 rtl/pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Sequencer for a 5-stage MIPS pipeline. It watches the load in EX against the
//   source registers of the instruction in ID and inserts a single-cycle
//   load-use stall. When MEM reports a taken branch (pcsrc), it squashes the
//   younger instructions in IF/ID, ID/EX and EX/MEM and then holds a flush
//   window. Stall and flush events are counted in saturating debug counters.
//
// Handshake / timing contract:
//   There is no valid/ready handshake. Every control output is a same-cycle,
//   combinational function of the current FSM state and the inputs, and the
//   pipeline registers act on it at the next rising edge of clk. While rst is
//   high the front end is frozen (pc_write=0, ifid_write=0) and all three
//   flush strobes are high.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous, active-high reset
//   pcsrc        in   taken branch, registered in MEM
//   ex_memread   in   instruction in EX is a load
//   ex_rt        in   destination rt of the instruction in EX
//   id_rs        in   rs of the instruction in ID
//   id_rt        in   rt of the instruction in ID
//   id_uses_rt   in   instruction in ID reads rt
//   pc_write     out  PC load enable
//   ifid_write   out  IF/ID load enable
//   ifid_flush   out  zero IF/ID on the next edge
//   idex_flush   out  zero ID/EX control bits on the next edge
//   exmem_flush  out  zero EX/MEM control bits on the next edge
//   state        out  FSM state: 0 RUN, 1 STALL, 2 FLUSH
//   stall_count  out  load-use stalls taken, saturating
//   flush_count  out  branch flushes taken, saturating
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int REG_W        = 5,
   parameter int FLUSH_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pcsrc,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_STALL   = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_t;

   // The window counter only ever holds FLUSH_CYCLES-1 down to 1.
   localparam int WIN_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(FLUSH_CYCLES - 1);
   localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
   // A one-cycle window is just the pcsrc cycle itself, so go straight back to RUN.
   localparam state_t BRANCH_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

   state_t           state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic             hazard;
   logic             stall_inc;
   logic             flush_inc;

   assign hazard = ex_memread && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   // Next-state and control outputs.
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      case (state_q)
         ST_RUN: begin
            // A taken branch wins; a load-use hazard in the same cycle belongs to
            // a squashed instruction and is dropped.
            if (pcsrc) begin
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               flush_inc   = 1'b1;
               win_d       = WIN_LOAD;
               state_d     = BRANCH_NEXT;
            end else if (hazard) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
               stall_inc  = 1'b1;
               state_d    = ST_STALL;
            end
         end
         ST_STALL: begin
            // The bubble is now in EX, so the hazard has resolved; only a branch
            // can redirect this cycle.
            if (pcsrc) begin
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               flush_inc   = 1'b1;
               win_d       = WIN_LOAD;
               state_d     = BRANCH_NEXT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // pcsrc here can only come from a squashed slot, so it is ignored.
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            win_d       = win_q - WIN_ONE;
            if (win_q <= WIN_ONE) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_inc && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
         if (flush_inc && (flush_count != '1)) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl. Two instances share the stimulus:
//   one with 16-bit counters and one with 2-bit counters for saturation. A
//   behavioural model (a flush-window countdown, a "stalled last cycle" flag and
//   unbounded event tallies) predicts every output on every falling edge, and
//   a few literal expectations pin specific cycles.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int REG_W = 5;
   localparam int FC    = 3;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             pcsrc = 1'b0;
   logic             ex_memread = 1'b0;
   logic [REG_W-1:0] ex_rt = '0;
   logic [REG_W-1:0] id_rs = '0;
   logic [REG_W-1:0] id_rt = '0;
   logic             id_uses_rt = 1'b0;

   logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
   logic [1:0]  state;
   logic [15:0] stall_count, flush_count;

   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush;
   logic [1:0]  s_state;
   logic [1:0]  s_stall_count, s_flush_count;

   pipeline_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .pcsrc(pcsrc), .ex_memread(ex_memread),
      .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush), .state(state),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   pipeline_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .pcsrc(pcsrc), .ex_memread(ex_memread),
      .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
      .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .state(s_state),
      .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // driver: apply one cycle of inputs just after the rising edge, then wait
   // for the falling edge where outputs are sampled.
   task automatic cyc(input logic r, input logic p, input logic mr,
                      input logic [REG_W-1:0] ert, input logic [REG_W-1:0] irs,
                      input logic [REG_W-1:0] irt, input logic ur);
      @(posedge clk);
      #1;
      rst = r; pcsrc = p; ex_memread = mr;
      ex_rt = ert; id_rs = irs; id_rt = irt; id_uses_rt = ur;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   // behavioural model
   int m_left = 0;     // flush-window cycles still to run after the pcsrc cycle
   bit m_stalled = 0;  // a stall was taken in the previous cycle
   int m_scnt = 0, m_fcnt = 0;
   int n_left = 0;
   bit n_stalled = 0;
   int n_scnt = 0, n_fcnt = 0;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // scoreboard: compare process on every falling edge
   always @(negedge clk) begin
      int e_pcw, e_ifw, e_iff, e_idf, e_emf, e_st;
      bit hz;
      hz = ex_memread && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      if (rst) begin
         m_left = 0; m_stalled = 0; m_scnt = 0; m_fcnt = 0;
         e_pcw = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_emf = 1; e_st = 0;
      end else begin
         e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_emf = 0;
         e_st = (m_left > 0) ? 2 : (m_stalled ? 1 : 0);
      end
      n_left = 0; n_stalled = 0; n_scnt = m_scnt; n_fcnt = m_fcnt;
      if (!rst) begin
         if (m_left > 0) begin
            e_idf = 1; e_emf = 1;
            n_left = m_left - 1;
         end else if (pcsrc) begin
            e_iff = 1; e_idf = 1; e_emf = 1;
            n_left = FC - 1;
            n_fcnt = m_fcnt + 1;
         end else if (hz && !m_stalled) begin
            e_pcw = 0; e_ifw = 0; e_idf = 1;
            n_stalled = 1;
            n_scnt = m_scnt + 1;
         end
      end
      chk("pc_write", pc_write, e_pcw);
      chk("ifid_write", ifid_write, e_ifw);
      chk("ifid_flush", ifid_flush, e_iff);
      chk("idex_flush", idex_flush, e_idf);
      chk("exmem_flush", exmem_flush, e_emf);
      chk("state", state, e_st);
      chk("stall_count", stall_count, sat(m_scnt, 65535));
      chk("flush_count", flush_count, sat(m_fcnt, 65535));
      chk("sat_state", s_state, e_st);
      chk("sat_pc_write", s_pc_write, e_pcw);
      chk("sat_stall_count", s_stall_count, sat(m_scnt, 3));
      chk("sat_flush_count", s_flush_count, sat(m_fcnt, 3));
   end

   always @(posedge clk) begin
      if (!rst) begin
         m_left = n_left; m_stalled = n_stalled; m_scnt = n_scnt; m_fcnt = n_fcnt;
      end
   end

   // directed stimulus with literal expectations
   initial begin
      // reset held for two cycles, then release
      cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("lit_rst_pc_write", pc_write, 0);
      chk("lit_rst_ifid_flush", ifid_flush, 1);
      cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle();
      chk("lit_run_state", state, 0);
      chk("lit_run_pc_write", pc_write, 1);

      // load-use on rs: one-cycle stall, hazard ignored in STALL
      cyc(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b0);
      chk("lit_lu_pc_write", pc_write, 0);
      chk("lit_lu_ifid_write", ifid_write, 0);
      chk("lit_lu_idex_flush", idex_flush, 1);
      cyc(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b0);
      chk("lit_lu_state_stall", state, 1);
      chk("lit_lu_pc_write2", pc_write, 1);
      idle();
      chk("lit_lu_state_run", state, 0);
      chk("lit_lu_stall_count", stall_count, 1);

      // no false hazard: $zero, and rt match without rt use
      cyc(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
      chk("lit_zero_pc_write", pc_write, 1);
      cyc(1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0);
      chk("lit_rt_unused_pc_write", pc_write, 1);
      cyc(1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 1'b1);
      chk("lit_not_load_pc_write", pc_write, 1);
      // rt match with rt use does stall
      cyc(1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1);
      chk("lit_rt_used_pc_write", pc_write, 0);
      idle();
      idle();
      chk("lit_stall_count_2", stall_count, 2);

      // branch in RUN, hazard inside the window is ignored
      cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("lit_br_ifid_flush", ifid_flush, 1);
      chk("lit_br_exmem_flush", exmem_flush, 1);
      chk("lit_br_pc_write", pc_write, 1);
      cyc(1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
      chk("lit_win1_state", state, 2);
      chk("lit_win1_ifid_flush", ifid_flush, 0);
      chk("lit_win1_pc_write", pc_write, 1);
      cyc(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
      chk("lit_win2_state", state, 2);
      chk("lit_win2_idex_flush", idex_flush, 1);
      idle();
      chk("lit_br_end_state", state, 0);
      chk("lit_br_flush_count", flush_count, 1);
      chk("lit_br_stall_count", stall_count, 2);

      // simultaneous pcsrc and hazard: flush path only
      cyc(1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
      chk("lit_sim_pc_write", pc_write, 1);
      chk("lit_sim_ifid_flush", ifid_flush, 1);
      idle();
      idle();
      idle();
      chk("lit_sim_stall_count", stall_count, 2);
      chk("lit_sim_flush_count", flush_count, 2);

      // pcsrc while in STALL goes to FLUSH
      cyc(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("lit_stbr_state", state, 1);
      chk("lit_stbr_ifid_flush", ifid_flush, 1);
      idle();
      chk("lit_stbr_next_state", state, 2);
      idle();
      idle();
      chk("lit_stbr_flush_count", flush_count, 3);

      // reset asserted in the middle of a flush window
      cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      idle();
      chk("lit_mid_state", state, 2);
      cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("lit_mid_rst_pc_write", pc_write, 0);
      chk("lit_mid_rst_ifid_write", ifid_write, 0);
      chk("lit_mid_rst_exmem_flush", exmem_flush, 1);
      idle();
      chk("lit_post_rst_state", state, 0);
      chk("lit_post_rst_stall_count", stall_count, 0);
      chk("lit_post_rst_flush_count", flush_count, 0);

      // back-to-back dependent loads: each stalls once; 5 stalls saturate CNT_W=2
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 5'd12, 5'd12, 5'd0, 1'b0);
      end
      idle();
      chk("lit_b2b_stall_count", stall_count, 5);
      chk("lit_sat_stall_count", s_stall_count, 3);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
